// File: rtl/crc8_pkg.sv
// Shared definitions for the CRC-8 framer and its CRC engine.
// Holds the framer state encoding, the CRC seed, the frame-counter width and
// the byte-wise CRC-8 update used by the engine (MSB-first, no reflection).
package crc8_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      PASS  = 2'd1,
      CRC   = 2'd2
   } state_t;

   localparam logic [7:0] CRC_INIT    = 8'h00;
   localparam int         FRAME_CNT_W = 16;

   function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                            input logic [7:0] data,
                                            input logic [7:0] poly);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/crc8_frame_tx_crc8.sv
// Byte-wide CRC-8 engine. rst_i is a synchronous clear back to CRC_INIT so the
// framer can clear it from state logic without a combinational async reset.
// crc_o holds its value whenever data_valid_i is low.
module crc8
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLYNOMIAL = 8'h07
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       data_valid_i,
   input  logic [7:0] data_i,
   output logic [7:0] crc_o
);

   // CRC register: clear, fold one byte, or hold.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         crc_o <= CRC_INIT;
      end else if (data_valid_i) begin
         crc_o <= crc8_next(crc_o, data_i, POLYNOMIAL);
      end
   end

endmodule

// File: rtl/crc8_frame_tx.sv
// Transmit framer: forwards payload bytes unchanged and appends one CRC-8 byte
// per frame, clearing the CRC engine between frames.
// Optional macro CRC8_FRAME_TX_FRAME_CNT_EN adds frame_count_o, a wrapping
// count of CRC-byte handshakes.
//
// state | meaning
// ------+----------------------------------------------------------
// CLEAR | input stalled, CRC engine cleared for one cycle
// PASS  | payload bytes accepted and forwarded, folded into the CRC
// CRC   | input stalled, waiting to load the CRC byte (m_last_o=1)
module crc8_frame_tx
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLYNOMIAL = 8'h07
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [7:0]             s_data_i,
   input  logic                   s_valid_i,
   input  logic                   s_last_i,
   output logic                   s_ready_o,
   output logic [7:0]             m_data_o,
   output logic                   m_valid_o,
   output logic                   m_last_o,
   input  logic                   m_ready_i
`ifdef CRC8_FRAME_TX_FRAME_CNT_EN
   ,
   output logic [FRAME_CNT_W-1:0] frame_count_o
`endif
);

   state_t     state, state_nxt;
   logic       free;
   logic       load;
   logic [7:0] load_data;
   logic       load_last;
   logic       crc_clr;
   logic       crc_dv;
   logic [7:0] crc;

   assign free = !m_valid_o || m_ready_i;

   crc8 #(
      .POLYNOMIAL (POLYNOMIAL)
   ) u_crc8 (
      .clk_i        (clk_i),
      .rst_i        (rst_i || crc_clr),
      .data_valid_i (crc_dv),
      .data_i       (s_data_i),
      .crc_o        (crc)
   );

   // State register; reset lands in CLEAR so the engine is always re-seeded.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, input handshake and output-register load selection.
   always_comb begin
      state_nxt = state;
      s_ready_o = 1'b0;
      crc_clr   = 1'b0;
      crc_dv    = 1'b0;
      load      = 1'b0;
      load_data = s_data_i;
      load_last = 1'b0;
      case (state)
         CLEAR: begin
            crc_clr   = 1'b1;
            state_nxt = PASS;
         end
         PASS: begin
            s_ready_o = free;
            if (s_valid_i && free) begin
               load   = 1'b1;
               crc_dv = 1'b1;
               if (s_last_i) begin
                  state_nxt = CRC;
               end
            end
         end
         CRC: begin
            if (free) begin
               load      = 1'b1;
               load_data = crc;
               load_last = 1'b1;
               state_nxt = CLEAR;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Output register: reload when free, otherwise drop valid once drained.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_data_o  <= 8'h00;
         m_valid_o <= 1'b0;
         m_last_o  <= 1'b0;
      end else if (load) begin
         m_data_o  <= load_data;
         m_valid_o <= 1'b1;
         m_last_o  <= load_last;
      end else if (m_ready_i) begin
         m_valid_o <= 1'b0;
         m_last_o  <= 1'b0;
      end
   end

`ifdef CRC8_FRAME_TX_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] frame_cnt;

   // Count completed frames on the CRC-byte handshake; wraps naturally.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         frame_cnt <= '0;
      end else if (m_valid_o && m_ready_i && m_last_o) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   assign frame_count_o = frame_cnt;
`endif

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Bench for crc8_frame_tx: scoreboard of expected output bytes checked by a
// negedge monitor, plus per-scenario tasks for timing and reset behaviour.
module tb_crc8_frame_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       m_ready = 1'b1;
`ifdef CRC8_FRAME_TX_FRAME_CNT_EN
   logic [15:0] frame_count;
   logic [15:0] fc_exp = 16'h0000;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int first_acc_cyc = 0;
   int last_acc_cyc = 0;
   bit rand_ready = 1'b0;
   int stall_left = 0;

   logic [8:0] sb[$];
   int         hs_cyc[$];

   bit         stall_prev = 1'b0;
   logic [7:0] held_d;
   logic       held_l;

   crc8_frame_tx #(.POLYNOMIAL(8'h07)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .s_data_i  (s_data),
      .s_valid_i (s_valid),
      .s_last_i  (s_last),
      .s_ready_o (s_ready),
      .m_data_o  (m_data),
      .m_valid_o (m_valid),
      .m_last_o  (m_last),
      .m_ready_i (m_ready)
`ifdef CRC8_FRAME_TX_FRAME_CNT_EN
      ,
      .frame_count_o (frame_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: constant 1, or random stalls of 1..10 cycles.
   always begin
      @(posedge clk);
      #1;
      if (!rand_ready) begin
         m_ready = 1'b1;
         stall_left = 0;
      end else if (stall_left > 0) begin
         m_ready = 1'b0;
         stall_left--;
      end else if ($urandom_range(0, 1) == 0) begin
         m_ready = 1'b0;
         stall_left = $urandom_range(0, 9);
      end else begin
         m_ready = 1'b1;
      end
   end

   // Output monitor: hold stability while stalled, scoreboard on handshake.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== held_d || m_last !== held_l) begin
               errors++;
               $display("FAIL stall_hold: got valid=%0b data=%02h last=%0b want valid=1 data=%02h last=%0b",
                        m_valid, m_data, m_last, held_d, held_l);
            end
         end
         if (m_valid && m_ready) begin
            logic [8:0] exp;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: got data=%02h last=%0b want no output", m_data, m_last);
            end else begin
               exp = sb.pop_front();
               if ({m_data, m_last} !== exp) begin
                  errors++;
                  $display("FAIL out_byte: got data=%02h last=%0b want data=%02h last=%0b",
                           m_data, m_last, exp[8:1], exp[0]);
               end
            end
            hs_cyc.push_back(cyc);
            stall_prev = 1'b0;
         end else if (m_valid) begin
            stall_prev = 1'b1;
            held_d = m_data;
            held_l = m_last;
         end else begin
            stall_prev = 1'b0;
         end
`ifdef CRC8_FRAME_TX_FRAME_CNT_EN
         checks++;
         if (frame_count !== fc_exp) begin
            errors++;
            $display("FAIL frame_count: got %04h want %04h", frame_count, fc_exp);
         end
         if (m_valid && m_ready && m_last) fc_exp = fc_exp + 16'h1;
`endif
      end
   end

   task automatic send_frame(input logic [7:0] bytes[$], input bit with_last,
                             input logic [7:0] exp_crc);
      @(posedge clk);
      #1;
      for (int i = 0; i < bytes.size(); i++) begin
         bit acc;
         int n;
         acc = 1'b0;
         n = 0;
         s_valid = 1'b1;
         s_data = bytes[i];
         s_last = with_last && (i == bytes.size() - 1);
         while (!acc) begin
            @(negedge clk);
            if (s_ready) begin
               acc = 1'b1;
               sb.push_back({bytes[i], 1'b0});
               if (i == 0) first_acc_cyc = cyc;
               last_acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (!acc && ++n > 200) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: got s_ready=0 for 200 cycles want accept of byte %0d", i);
               break;
            end
         end
      end
      s_valid = 1'b0;
      s_last = 1'b0;
      if (with_last) sb.push_back({exp_crc, 1'b1});
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d bytes pending want 0", sb.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] q[$];
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0b want 0", m_valid); end
      if (m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %0b want 0", m_last); end
      if (m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data: got %02h want 00", m_data); end
      if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %0b want 0", s_ready); end
      @(posedge clk);
      #1;
      rst = 1'b0;
`ifdef CRC8_FRAME_TX_FRAME_CNT_EN
      fc_exp = 16'h0000;
`endif
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL clear_s_ready: got %0b want 0", s_ready); end
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL pass_s_ready: got %0b want 1", s_ready); end
      q = '{8'h01};
      send_frame(q, 1'b1, 8'h07);
      wait_drain(50);
   endtask

   task automatic test_back_to_back();
      logic [7:0] q[$];
      int c;
      hs_cyc.delete();
      q = '{8'h01, 8'h02};
      send_frame(q, 1'b1, 8'h1B);
      c = last_acc_cyc;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_n1: got %0b want 0", s_ready); end
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_n2: got %0b want 0", s_ready); end
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1 || cyc != c + 3) begin
         errors++;
         $display("FAIL b2b_ready_n3: got s_ready=%0b at cycle %0d want 1 at cycle %0d", s_ready, cyc, c + 3);
      end
      wait_drain(50);
      checks++;
      if (hs_cyc.size() != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d outputs want 3", hs_cyc.size());
      end else begin
         checks += 3;
         if (hs_cyc[0] != first_acc_cyc + 1) begin
            errors++; $display("FAIL b2b_latency: got cycle %0d want %0d", hs_cyc[0], first_acc_cyc + 1);
         end
         if (hs_cyc[1] != hs_cyc[0] + 1) begin
            errors++; $display("FAIL b2b_gap: got cycle %0d want %0d", hs_cyc[1], hs_cyc[0] + 1);
         end
         if (hs_cyc[2] != c + 2) begin
            errors++; $display("FAIL b2b_crc_latency: got cycle %0d want %0d", hs_cyc[2], c + 2);
         end
      end
   endtask

   task automatic test_check_value();
      logic [7:0] q[$];
      q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      send_frame(q, 1'b1, 8'hF4);
      q = '{8'h00};
      send_frame(q, 1'b1, 8'h00);
      wait_drain(100);
   endtask

   task automatic test_stalls();
      logic [7:0] q[$];
      rand_ready = 1'b1;
      q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      repeat (4) send_frame(q, 1'b1, 8'hF4);
      q = '{8'h01, 8'h02};
      send_frame(q, 1'b1, 8'h1B);
      wait_drain(500);
      rand_ready = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] q[$];
      q = '{8'h31, 8'h32, 8'h33, 8'h34};
      send_frame(q, 1'b0, 8'h00);
      wait_drain(50);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs: got m_valid=%0b s_ready=%0b want 0 0", m_valid, s_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
`ifdef CRC8_FRAME_TX_FRAME_CNT_EN
      fc_exp = 16'h0000;
`endif
      q = '{8'h01};
      send_frame(q, 1'b1, 8'h07);
      wait_drain(50);
      repeat (5) @(negedge clk);
   endtask

`ifdef CRC8_FRAME_TX_FRAME_CNT_EN
   task automatic test_frame_count();
      logic [7:0] q[$];
      q = '{8'h01};
      @(negedge clk);
      checks++;
      if (frame_count !== 16'h0000) begin errors++; $display("FAIL fc_start: got %04h want 0000", frame_count); end
      for (int k = 1; k <= 3; k++) begin
         send_frame(q, 1'b1, 8'h07);
         wait_drain(50);
         checks++;
         if (frame_count !== 16'(k)) begin
            errors++; $display("FAIL fc_step: got %04h want %04h", frame_count, 16'(k));
         end
      end
      @(posedge clk);
      #1;
      force dut.frame_cnt = 16'hFFFF;
      fc_exp = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt;
      send_frame(q, 1'b1, 8'h07);
      wait_drain(50);
      checks++;
      if (frame_count !== 16'h0000) begin errors++; $display("FAIL fc_wrap: got %04h want 0000", frame_count); end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_check_value();
      test_stalls();
      test_reset_mid_frame();
`ifdef CRC8_FRAME_TX_FRAME_CNT_EN
      test_frame_count();
`endif
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL final_scoreboard: got %0d pending want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
